// File: rtl/marker_scan_ctrl.sv
// Sequences the row stripe detector across a frame, tracks a vertical run
// of consistent row hits and publishes one marker result per frame.
module marker_scan_ctrl #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int NT_THRES = 40,
  parameter int X_TOL    = 16,
  parameter int GAP_MAX  = 4,
  parameter int MIN_ROWS = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        done_in,
  input  logic [10:0] coord_in,
  input  logic [10:0] centre_width_in,
  input  logic [10:0] nt_probability_in,
  output logic        det_rst_out,
  output logic        result_valid_out,
  input  logic        result_ready_in,
  output logic [10:0] marker_x_out,
  output logic [9:0]  marker_y_out,
  output logic [10:0] marker_width_out,
  output logic [10:0] marker_score_out,
  output logic [9:0]  marker_rows_out,
  output logic        overrun_out
);

  typedef enum logic [1:0] {SYNC, SCAN, PUBLISH} state_t;

  localparam logic [10:0] H_END = 11'(H_ACTIVE);
  localparam logic [9:0]  V_END = 10'(V_ACTIVE);

  state_t      state_q, state_d;
  logic        det_rst_q, det_rst_d;
  logic        row_hit_q, row_hit_d;
  logic [10:0] row_x_q, row_x_d;
  logic [10:0] row_w_q, row_w_d;
  logic [10:0] row_s_q, row_s_d;
  logic [9:0]  trk_rows_q, trk_rows_d;
  logic [10:0] trk_x_q, trk_x_d;
  logic [9:0]  y_first_q, y_first_d;
  logic [9:0]  y_last_q, y_last_d;
  logic [10:0] best_x_q, best_x_d;
  logic [10:0] best_w_q, best_w_d;
  logic [10:0] best_s_q, best_s_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic [10:0] mx_q, mx_d;
  logic [9:0]  my_q, my_d;
  logic [10:0] mw_q, mw_d;
  logic [10:0] ms_q, ms_d;
  logic [9:0]  mr_q, mr_d;

  logic        row_start, row_end, frame_end, frame_start;
  logic        cand, hit, joins, jump;
  logic [10:0] ex, ew, es, dx;
  logic [9:0]  dy;
  logic [10:0] y_sum;

  assign row_start   = hcount_in == 11'd0 && vcount_in < V_END;
  assign row_end     = hcount_in == H_END && vcount_in < V_END;
  assign frame_end   = hcount_in == 11'd0 && vcount_in == V_END;
  assign frame_start = hcount_in == 11'd0 && vcount_in == 10'd0;

  // a done on the row-end cycle is folded in before the row commits
  assign cand = done_in && nt_probability_in <= 11'(NT_THRES)
             && nt_probability_in < row_s_q;
  assign hit  = row_hit_q || cand;
  assign ex   = cand ? coord_in : row_x_q;
  assign ew   = cand ? centre_width_in : row_w_q;
  assign es   = cand ? nt_probability_in : row_s_q;

  assign dx    = ex >= trk_x_q ? ex - trk_x_q : trk_x_q - ex;
  assign dy    = vcount_in - y_last_q;
  assign joins = dx <= 11'(X_TOL) && dy <= 10'(GAP_MAX);
  assign jump  = vcount_in < y_last_q;
  assign y_sum = {1'b0, y_first_q} + {1'b0, y_last_q};

  // next-state, row/track update and result publication
  always_comb begin
    state_d    = state_q;
    det_rst_d  = 1'b0;
    row_hit_d  = row_hit_q;
    row_x_d    = row_x_q;
    row_w_d    = row_w_q;
    row_s_d    = row_s_q;
    trk_rows_d = trk_rows_q;
    trk_x_d    = trk_x_q;
    y_first_d  = y_first_q;
    y_last_d   = y_last_q;
    best_x_d   = best_x_q;
    best_w_d   = best_w_q;
    best_s_d   = best_s_q;
    valid_d    = valid_q && !result_ready_in;
    ovr_d      = 1'b0;
    mx_d       = mx_q;
    my_d       = my_q;
    mw_d       = mw_q;
    ms_d       = ms_q;
    mr_d       = mr_q;
    unique case (state_q)
      SYNC: begin
        det_rst_d = 1'b1;
        if (frame_start) begin
          state_d   = SCAN;
          row_hit_d = 1'b0;
          row_s_d   = '1;
        end
      end
      SCAN: begin
        if (jump) begin
          state_d    = SYNC;
          det_rst_d  = 1'b1;
          trk_rows_d = '0;
          y_first_d  = '0;
          y_last_d   = '0;
        end else if (frame_end) begin
          state_d = PUBLISH;
        end else if (row_start) begin
          det_rst_d = 1'b1;
          row_hit_d = 1'b0;
          row_s_d   = '1;
        end else begin
          if (cand) begin
            row_hit_d = 1'b1;
            row_x_d   = coord_in;
            row_w_d   = centre_width_in;
            row_s_d   = nt_probability_in;
          end
          if (row_end && hit) begin
            if (trk_rows_q == 10'd0) begin
              trk_x_d    = ex;
              y_first_d  = vcount_in;
              y_last_d   = vcount_in;
              trk_rows_d = 10'd1;
              best_x_d   = ex;
              best_w_d   = ew;
              best_s_d   = es;
            end else if (joins) begin
              y_last_d = vcount_in;
              if (trk_rows_q != 10'h3FF)
                trk_rows_d = trk_rows_q + 10'd1;
              if (es < best_s_q) begin
                best_x_d = ex;
                best_w_d = ew;
                best_s_d = es;
              end
            end
          end
        end
      end
      PUBLISH: begin
        if (trk_rows_q >= 10'(MIN_ROWS)) begin
          if (!valid_q || result_ready_in) begin
            valid_d = 1'b1;
            mx_d    = best_x_q;
            my_d    = y_sum[10:1];
            mw_d    = best_w_q;
            ms_d    = best_s_q;
            mr_d    = trk_rows_q;
          end else begin
            ovr_d = 1'b1;
          end
        end
        trk_rows_d = '0;
        y_first_d  = '0;
        y_last_d   = '0;
        state_d    = SCAN;
      end
      default: state_d = SYNC;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= SYNC;
      det_rst_q  <= 1'b1;
      row_hit_q  <= 1'b0;
      row_x_q    <= '0;
      row_w_q    <= '0;
      row_s_q    <= '1;
      trk_rows_q <= '0;
      trk_x_q    <= '0;
      y_first_q  <= '0;
      y_last_q   <= '0;
      best_x_q   <= '0;
      best_w_q   <= '0;
      best_s_q   <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      mx_q       <= '0;
      my_q       <= '0;
      mw_q       <= '0;
      ms_q       <= '0;
      mr_q       <= '0;
    end else begin
      state_q    <= state_d;
      det_rst_q  <= det_rst_d;
      row_hit_q  <= row_hit_d;
      row_x_q    <= row_x_d;
      row_w_q    <= row_w_d;
      row_s_q    <= row_s_d;
      trk_rows_q <= trk_rows_d;
      trk_x_q    <= trk_x_d;
      y_first_q  <= y_first_d;
      y_last_q   <= y_last_d;
      best_x_q   <= best_x_d;
      best_w_q   <= best_w_d;
      best_s_q   <= best_s_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      mx_q       <= mx_d;
      my_q       <= my_d;
      mw_q       <= mw_d;
      ms_q       <= ms_d;
      mr_q       <= mr_d;
    end
  end

  assign det_rst_out      = det_rst_q;
  assign result_valid_out = valid_q;
  assign overrun_out      = ovr_q;
  assign marker_x_out     = mx_q;
  assign marker_y_out     = my_q;
  assign marker_width_out = mw_q;
  assign marker_score_out = ms_q;
  assign marker_rows_out  = mr_q;

endmodule
